multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Multi-cycle main controller for the MIPS-subset datapath. It replaces the single-cycle opcode decoder with a state machine that sequences one instruction at a time through shared memory, ALU and register-file resources: fetch, decode, execute, memory, writeback. Memory accesses use a ready handshake so fetch and data accesses can stall. It sits between the instruction register (OpCode source) and the datapath muxes and write enables.

Parameters:
OP_W, 6, opcode width
ALUOP_W, 3, ALU-control code width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
run  in  1  level; 1 = keep fetching, sampled at instruction boundaries and in IDLE
OpCode  in  6  instr[31:26] from the instruction register, valid from DECODE onward
mem_ready  in  1  memory completes the current read/write this cycle
PCWrite  out  1  unconditional PC write enable
PCWriteCond  out  1  PC write if ALU zero (beq)
IorD  out  1  0 = PC address, 1 = ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  instruction register load
MemToReg  out  1  1 = MDR to register file
RegDst  out  1  1 = rd, 0 = rt
RegWrite  out  1  register file write enable
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
ALUOp  out  3  ALU-control code
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
instr_done  out  1  one-cycle pulse in the last cycle of each instruction
illegal_op  out  1  high while in HALT
state_o  out  4  current state, debug

Behaviour:
- Reset (rst_n=0, async): state=IDLE, op_q=0. All outputs 0 during reset and in IDLE.
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, HALT.
- IDLE -> FETCH when run=1; otherwise stay.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=001, PCSource=00. PCWrite=IRWrite=mem_ready, so the PC advances exactly once. Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: op_q<=OpCode. ALUSrcA=0, ALUSrcB=11, ALUOp=001 to precompute the branch target. Next state by OpCode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEM_ADDR
  - 001000, 001010, 001100 or 001101 -> EXEC_I
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> HALT
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=001. Go to MEM_READ if op_q=lw, else MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0.
- MEM_WRITE: MemWrite=1, IorD=1. Wait for mem_ready. This is the final cycle only when mem_ready=1.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=111, then R_WB (RegWrite=1, RegDst=1, MemToReg=0).
- EXEC_I: ALUSrcA=1, ALUSrcB=10. ALUOp: addi 101, slti 100, andi 011, ori 010. Then I_WB (RegWrite=1, RegDst=0, MemToReg=0).
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=000, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
- Final states are MEM_WB, MEM_WRITE (with mem_ready=1), R_WB, I_WB, BRANCH and JUMP.
  - instr_done=1 in a final state.
  - Next state is FETCH if run=1, else IDLE.
- HALT: illegal_op=1, all enables 0. Sticky until reset. run is ignored.
- Outputs not listed for a state are 0. Outputs are combinational from state (Moore), except the mem_ready-gated PCWrite/IRWrite in FETCH.
- Latency with mem_ready always 1:
  - beq, j: 3 cycles
  - R-type, I-type ALU, sw: 4 cycles
  - lw: 5 cycles
  - each mem_ready=0 cycle adds 1.
- run drops mid-instruction: the instruction completes, then the FSM goes to IDLE.
- rst_n asserted mid-instruction: immediate IDLE. No write enable may be high in the reset cycle.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum (4-bit)
  - opcode constants (OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J)
  - ALUOp codes (ALU_ADD=001, ALU_SUB=000, ALU_RTYPE=111, ALU_ADDI=101, ALU_SLTI=100, ALU_ANDI=011, ALU_ORI=010)
  - ALUSrcB and PCSource encodings
- One sub-module, mc_out_decode: purely combinational, state + op_q + mem_ready -> control vector. The FSM next-state logic stays in the top level.

Test Plan:
- Reset/run: rst_n=0 mid-EXEC_R -> state_o=IDLE and all enables 0 the same cycle. Release with run=0 -> stays IDLE. run=1 -> FETCH next cycle.
- R-type, mem_ready=1: OpCode=000000 -> states FETCH, DECODE, EXEC_R, R_WB. PCWrite=1 once. ALUOp=111 in EXEC_R. RegWrite=1, RegDst=1 in R_WB. instr_done on cycle 4.
- lw with stalls: OpCode=100011, mem_ready low 2 cycles in FETCH and 3 in MEM_READ -> 10 cycles total. PCWrite/IRWrite high exactly 1 cycle. MemToReg=1 and RegWrite=1 in MEM_WB.
- sw then beq: sw -> MemWrite=1 and IorD=1 held until mem_ready, no RegWrite. beq -> PCWriteCond=1, PCSource=01, ALUOp=000, done in 3 cycles.
- I-type sweep: addi/slti/andi/ori -> ALUOp 101/100/011/010 in EXEC_I, ALUSrcB=10. j -> PCWrite=1, PCSource=10 in JUMP.
- Illegal: OpCode=111111 -> HALT after DECODE. illegal_op=1 held 20 cycles with run=1 and no enables. Only rst_n clears it.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset main controller.
package mips_ctrl_pkg;

  localparam int OP_W    = 6;
  localparam int ALUOP_W = 3;

  // Controller states (4-bit so the value can be exported directly on state_o)
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_R_WB      = 4'd8,
    S_EXEC_I    = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  // Opcodes of the supported instruction subset
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALU-control codes
  localparam logic [2:0] ALU_SUB   = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_ORI   = 3'b010;
  localparam logic [2:0] ALU_ANDI  = 3'b011;
  localparam logic [2:0] ALU_SLTI  = 3'b100;
  localparam logic [2:0] ALU_ADDI  = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_S2 = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full control vector driven towards the datapath
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // ALU code for the immediate-ALU instructions; add is the harmless fallback
  function automatic logic [2:0] ialu_code(input logic [5:0] op);
    logic [2:0] code;
    case (op)
      OP_ADDI: code = ALU_ADDI;
      OP_SLTI: code = ALU_SLTI;
      OP_ANDI: code = ALU_ANDI;
      OP_ORI:  code = ALU_ORI;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational Moore output decode: state (+ latched opcode, + mem_ready for
// the handshake-gated fetch/store signals) to the datapath control vector.
module mc_out_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_op_q,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  // Every output defaults to 0; each state only raises what it needs
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_IDLE: begin
        o_ctrl = '0;
      end
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        // PC and IR update only on the cycle the read completes
        o_ctrl.pc_write  = i_mem_ready;
        o_ctrl.ir_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_S2;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.i_or_d     = 1'b1;
        o_ctrl.instr_done = i_mem_ready;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALU_RTYPE;
      end
      S_R_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ialu_code(i_op_q);
      end
      S_I_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_RT;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_HALT: begin
        o_ctrl.illegal_op = 1'b1;
      end
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback
// for one instruction at a time, with ready-handshaked memory accesses.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [OP_W-1:0]    OpCode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state_o
);

  state_t          r_state;
  state_t          w_next;
  state_t          w_after_done;
  logic [OP_W-1:0] r_op_q;
  ctrl_t           w_ctrl;

  // State register; reset drops straight to IDLE so no enable survives it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Opcode is captured in DECODE so later states do not depend on the IR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_q <= '0;
    end else if (r_state == S_DECODE) begin
      r_op_q <= OpCode;
    end else begin
      r_op_q <= r_op_q;
    end
  end

  // Next-state logic; run is only honoured at instruction boundaries and in IDLE
  always_comb begin
    w_next       = r_state;
    w_after_done = run ? S_FETCH : S_IDLE;
    case (r_state)
      S_IDLE:     w_next = run ? S_FETCH : S_IDLE;
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (OpCode)
          OP_RTYPE:                         w_next = S_EXEC_R;
          OP_LW, OP_SW:                     w_next = S_MEM_ADDR;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: w_next = S_EXEC_I;
          OP_BEQ:                           w_next = S_BRANCH;
          OP_J:                             w_next = S_JUMP;
          default:                          w_next = S_HALT;
        endcase
      end
      S_MEM_ADDR:  w_next = (r_op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: w_next = mem_ready ? w_after_done : S_MEM_WRITE;
      S_EXEC_R:    w_next = S_R_WB;
      S_EXEC_I:    w_next = S_I_WB;
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: w_next = w_after_done;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_IDLE;
    endcase
  end

  mc_out_decode u_out_decode (
    .i_state     (r_state),
    .i_op_q      (r_op_q),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign IorD        = w_ctrl.i_or_d;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign IRWrite     = w_ctrl.ir_write;
  assign MemToReg    = w_ctrl.mem_to_reg;
  assign RegDst      = w_ctrl.reg_dst;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign instr_done  = w_ctrl.instr_done;
  assign illegal_op  = w_ctrl.illegal_op;
  assign state_o     = r_state;

endmodule
